// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Receiver for a multiplexed 4-digit seven-segment scan bus. It samples the
// bus and only accepts a digit once it has been stable long enough. It then
// decodes the active-low segment pattern back to a 4-bit code, assembles a
// full frame and converts an all-BCD frame to binary.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   seg_sel     one-hot digit select, bit0 = units ... bit3 = thousands
//   sm          active-low segments, bit7 = a ... bit1 = g, bit0 = dp
//   clear       synchronous clear of flags, partial frame and timeout
//   digits      last committed frame {d3,d2,d1,d0}
//   score_bin   binary value of the last committed all-BCD frame
//   frame_valid one-cycle pulse following each commit
//   bcd_ok      last committed frame is all 0-9 or blank
//   sel_err     sticky: stable non-one-hot select seen
//   seg_err     sticky: stable undecodable pattern seen
//   stale       no commit within TIMEOUT cycles
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 8,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  seg_sel,
    input  logic [7:0]  sm,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [13:0] score_bin,
    output logic        frame_valid,
    output logic        bcd_ok,
    output logic        sel_err,
    output logic        seg_err,
    output logic        stale
);

    localparam logic [7:0]  RUN_MAX = 8'(STABLE_CYCLES);
    localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);

    // Returns {decodable, code}; dp is not part of the pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b0000001: return {1'b1, 4'h0};
            7'b1001111: return {1'b1, 4'h1};
            7'b0010010: return {1'b1, 4'h2};
            7'b0000110: return {1'b1, 4'h3};
            7'b1001100: return {1'b1, 4'h4};
            7'b0100100: return {1'b1, 4'h5};
            7'b0100000: return {1'b1, 4'h6};
            7'b0001111: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0000100: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b1100000: return {1'b1, 4'hB};
            7'b0110001: return {1'b1, 4'hC};
            7'b1000010: return {1'b1, 4'hD};
            7'b0110000: return {1'b1, 4'hE};
            7'b1111111: return {1'b1, 4'hF};
            default:    return {1'b0, 4'h0};
        endcase
    endfunction

    // Blank (F) is accepted as a leading/filler digit.
    function automatic logic all_bcd(input logic [15:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] > 4'd9 && d[i*4 +: 4] != 4'hF) ok = 1'b0;
        end
        return ok;
    endfunction

    // Horner evaluation from the thousands digit down; blank counts as 0.
    function automatic logic [13:0] to_bin(input logic [15:0] d);
        logic [13:0] acc;
        logic [3:0]  c;
        acc = '0;
        for (int i = 3; i >= 0; i--) begin
            c   = d[i*4 +: 4];
            acc = acc * 14'd10 + ((c == 4'hF) ? 14'd0 : {10'd0, c});
        end
        return acc;
    endfunction

    logic [11:0] sample_q;
    logic [7:0]  run_cnt;
    logic [3:0]  got;
    logic [15:0] to_cnt;
    logic [15:0] slot_q;

    logic [11:0] bus;
    logic        stable;
    logic        accept;
    logic [4:0]  dec;
    logic        sel_onehot;
    logic [3:0]  wr_mask;
    logic [3:0]  got_next;
    logic [15:0] frame_next;
    logic        commit;

    assign bus        = {seg_sel, sm};
    assign stable     = (bus == sample_q);
    // Fires only on the edge where the run counter reaches its saturation value.
    assign accept     = stable && (run_cnt == RUN_MAX - 8'd1);
    assign dec        = decode_seg(sample_q[7:1]);
    assign sel_onehot = $onehot(sample_q[11:8]);
    assign wr_mask    = (accept && sel_onehot && dec[4]) ? sample_q[11:8] : 4'b0000;
    assign got_next   = got | wr_mask;
    // A slot write under clear still happens, but cannot complete a frame.
    assign commit     = (got_next == 4'hF) && !clear;

    always_comb begin
        frame_next = slot_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) frame_next[i*4 +: 4] = dec[3:0];
        end
    end

    // Digit slots hold data only; they are always qualified by got.
    always_ff @(posedge clk) begin
        slot_q <= frame_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q    <= '0;
            run_cnt     <= '0;
            got         <= '0;
            to_cnt      <= '0;
            digits      <= 16'hFFFF;
            score_bin   <= '0;
            frame_valid <= 1'b0;
            bcd_ok      <= 1'b0;
            sel_err     <= 1'b0;
            seg_err     <= 1'b0;
            stale       <= 1'b0;
        end else begin
            sample_q    <= bus;
            if (!stable) begin
                run_cnt <= 8'd1;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 8'd1;
            end
            frame_valid <= commit;

            if (clear) begin
                got     <= '0;
                to_cnt  <= '0;
                sel_err <= 1'b0;
                seg_err <= 1'b0;
                stale   <= 1'b0;
            end else begin
                if (accept && !sel_onehot)          sel_err <= 1'b1;
                if (accept && sel_onehot && !dec[4]) seg_err <= 1'b1;

                if (commit) begin
                    got    <= '0;
                    to_cnt <= '0;
                    stale  <= 1'b0;
                    digits <= frame_next;
                    bcd_ok <= all_bcd(frame_next);
                    if (all_bcd(frame_next)) score_bin <= to_bin(frame_next);
                end else if (to_cnt == TO_MAX - 16'd1) begin
                    // Expiry happens once; the saturated counter does not re-discard later progress.
                    stale  <= 1'b1;
                    got    <= '0;
                    to_cnt <= TO_MAX;
                end else begin
                    got <= got_next;
                    if (to_cnt != TO_MAX) to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: directed scan sequences drive the bus while
// a monitor pops expected frames from a queue on every frame_valid pulse.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [3:0]  seg_sel;
    logic [7:0]  sm;
    logic        clear;
    logic [15:0] digits;
    logic [13:0] score_bin;
    logic        frame_valid;
    logic        bcd_ok;
    logic        sel_err;
    logic        seg_err;
    logic        stale;

    seg_scan_decoder #(.STABLE_CYCLES(8), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .seg_sel(seg_sel), .sm(sm), .clear(clear),
        .digits(digits), .score_bin(score_bin), .frame_valid(frame_valid),
        .bcd_ok(bcd_ok), .sel_err(sel_err), .seg_err(seg_err), .stale(stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment bytes with dp off (bit0 = 1).
    localparam logic [7:0] P0 = 8'h03;
    localparam logic [7:0] P1 = 8'h9F;
    localparam logic [7:0] P2 = 8'h25;
    localparam logic [7:0] P3 = 8'h0D;
    localparam logic [7:0] P4 = 8'h99;
    localparam logic [7:0] P9 = 8'h09;
    localparam logic [7:0] PE = 8'h61;

    typedef struct packed {
        logic [15:0] digits;
        logic [13:0] score;
        logic        bcd;
    } frame_t;

    frame_t exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int n_commits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic dwell(input logic [3:0] sel, input logic [7:0] pat, input int n);
        seg_sel = sel;
        sm      = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic sweep(input logic [7:0] u, input logic [7:0] t,
                         input logic [7:0] h, input logic [7:0] th);
        dwell(4'b0001, u, 16);
        dwell(4'b0010, t, 16);
        dwell(4'b0100, h, 16);
        dwell(4'b1000, th, 16);
    endtask

    // Monitor: every frame_valid pulse must match the oldest expected frame.
    initial begin
        frame_t e;
        forever begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1) begin
                n_commits++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_commit: digits %0h score %0d, no frame expected at %0t",
                             digits, score_bin, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_digits", 32'(digits), 32'(e.digits));
                    check("commit_score", 32'(score_bin), 32'(e.score));
                    check("commit_bcd_ok", 32'(bcd_ok), 32'(e.bcd));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; seg_sel = 4'b0001; sm = P4;
        repeat (2) @(negedge clk);
        check("rst_digits", 32'(digits), 32'hFFFF);
        check("rst_score", 32'(score_bin), 0);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_bcd_ok", 32'(bcd_ok), 0);
        check("rst_flags", 32'({sel_err, seg_err, stale}), 0);
        rst = 1'b0;

        // Plain sweeps of 1234.
        exp_q.push_back('{16'h1234, 14'd1234, 1'b1});
        sweep(P4, P3, P2, P1);
        check("sweep1_digits", 32'(digits), 32'h1234);
        check("sweep1_score", 32'(score_bin), 1234);
        exp_q.push_back('{16'h1234, 14'd1234, 1'b1});
        sweep(P4, P3, P2, P1);

        // Short glitch (would decode as units = 0) inside the units dwell.
        exp_q.push_back('{16'h1234, 14'd1234, 1'b1});
        dwell(4'b0001, P4, 10);
        dwell(4'b0001, 8'h02, 3);
        dwell(4'b0001, P4, 3);
        dwell(4'b0010, P3, 16);
        dwell(4'b0100, P2, 16);
        dwell(4'b1000, P1, 16);
        check("glitch_flags", 32'({sel_err, seg_err}), 0);

        // Units replaced by 8 with dp lit.
        exp_q.push_back('{16'h1238, 14'd1238, 1'b1});
        sweep(8'h00, P3, P2, P1);
        exp_q.push_back('{16'h1234, 14'd1234, 1'b1});
        sweep(P4, P3, P2, P1);

        // Error flags and clear.
        dwell(4'b0011, P1, 10);
        check("sel_err_set", 32'(sel_err), 1);
        check("seg_err_quiet", 32'(seg_err), 0);
        dwell(4'b0001, 8'hFC, 10);
        check("seg_err_set", 32'(seg_err), 1);
        check("sel_err_sticky", 32'(sel_err), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_flags", 32'({sel_err, seg_err}), 0);
        check("clear_keeps_digits", 32'(digits), 32'h1234);

        // Non-BCD frame: score_bin must hold 1234.
        exp_q.push_back('{16'hE100, 14'd1234, 1'b0});
        sweep(P0, P0, P1, PE);

        // Timeout with a two-digit partial frame (9,9) left behind.
        dwell(4'b0001, P9, 16);
        dwell(4'b0010, P9, 16);
        check("stale_before_timeout", 32'(stale), 0);
        dwell(4'b0010, P9, 1040);
        check("stale_set", 32'(stale), 1);
        dwell(4'b0100, P2, 16);
        dwell(4'b1000, P1, 16);
        check("stale_no_partial_commit", 32'(stale), 1);
        exp_q.push_back('{16'h1234, 14'd1234, 1'b1});
        dwell(4'b0001, P4, 16);
        dwell(4'b0010, P3, 16);
        check("stale_cleared", 32'(stale), 0);

        // Reset during the third digit of a sweep.
        dwell(4'b0001, P4, 16);
        dwell(4'b0010, P3, 16);
        dwell(4'b0100, P2, 5);
        rst = 1'b1;
        #1;
        check("midrst_digits", 32'(digits), 32'hFFFF);
        check("midrst_score", 32'(score_bin), 0);
        check("midrst_bcd_ok", 32'(bcd_ok), 0);
        check("midrst_flags", 32'({frame_valid, sel_err, seg_err, stale}), 0);
        @(negedge clk);
        rst = 1'b0;
        dwell(4'b0100, P2, 16);
        dwell(4'b1000, P1, 16);
        check("midrst_no_early_commit", 32'(digits), 32'hFFFF);
        exp_q.push_back('{16'h1234, 14'd1234, 1'b1});
        dwell(4'b0001, P4, 16);
        dwell(4'b0010, P3, 16);

        repeat (4) @(negedge clk);
        check("pending_frames", 32'(exp_q.size()), 0);
        check("commit_count", 32'(n_commits), 8);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
